mdio_ctrl: RTL and testbench
============================

# mdio_ctrl

Multi-port MDIO (IEEE 802.3 Clause 22) management controller for the GMII ethernet subsystem. It accepts PHY register read/write commands from one command channel per port and arbitrates between them round-robin. It serializes one 64-bit management frame at a time on the selected port's `mdio` line, using a shared MDC. On completion it returns read data or a write acknowledge with an error flag. Its MDIO pins connect to the same per-port `mdio` bus that the GMII ethernet BFM and PHY models expose.

## Interface
- `NUM_PORTS`, 4: number of ports, command channels and `mdio` lines; range 1..8.
- `MDC_DIV`, 10: clk cycles per MDC half-period; minimum 2.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in NUM_PORTS: per-port command request.
- `cmd_ready` out NUM_PORTS: per-port command accept. A command transfers when valid and ready are both 1.
- `cmd_wr` in NUM_PORTS: per-port operation, 1 = write, 0 = read.
- `cmd_phy` in 5*NUM_PORTS: per-port PHY address; port p uses bits [5p+4:5p].
- `cmd_reg` in 5*NUM_PORTS: per-port register address, packed as `cmd_phy`.
- `cmd_wdata` in 16*NUM_PORTS: per-port write data; port p uses bits [16p+15:16p].
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_port` out $clog2(NUM_PORTS) (min 1): port that owned the completed frame.
- `rsp_rdata` out 16: captured read data; 0 on writes.
- `rsp_err` out 1: read turnaround fault; always 0 on writes.
- `busy` out 1: high when state is not IDLE.
- `mdc` out 1: shared management clock.
- `mdio` inout NUM_PORTS: per-port management data.

## Operation
- States: IDLE, PRE, HDR, TA, DATA, DONE.
- Arbitration:
  - Round-robin pointer `rr`, reset to 0.
  - In IDLE, the grant goes to the first port p with `cmd_valid[p]`, searching from `rr` upward modulo NUM_PORTS.
  - `cmd_ready[p]` = (state==IDLE) & grant==p. It is combinational from registered state, `rr` and `cmd_valid`.
  - At most one bit of `cmd_ready` is high. It is 0 in every other state.
- On accept: latch the port, wr, phy, reg and wdata; set `rr` = (p+1) mod NUM_PORTS; go to PRE.
- Frame bit order, MSB first:
  - PRE: 32 × `1`.
  - HDR: `01` (ST), then OP (`01` write, `10` read), PHYAD[4:0], REGAD[4:0]; 14 bits.
  - TA, write: drive `1`,`0`.
  - TA, read: release `mdio` for both bits. Sample the second bit; if it is not 0, set `rsp_err`.
  - DATA, write: drive wdata[15:0].
  - DATA, read: release `mdio` and shift in 16 sampled bits. A sampled value that is not 0 (including z/x) is stored as 1.
- Only the owning port's `mdio` is ever driven. All other lines are z at all times. The owning line is z in IDLE, DONE, read TA and read DATA.
- DONE lasts one cycle: pulse `rsp_valid` with `rsp_port`, `rsp_rdata` and `rsp_err`, then go to IDLE.
- `rsp_port`, `rsp_rdata` and `rsp_err` hold their values until the next DONE.
- A read with `rsp_err`=1 still completes full DATA timing; rdata is whatever was sampled (0xFFFF when no PHY is present).

## Timing
- Reset values, applied asynchronously: state IDLE, `rr`=0, `mdc`=0, `mdio`=all z, `cmd_ready`=0, `rsp_valid`=0, `rsp_port`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0.
- Each bit occupies 2*MDC_DIV clks: MDC_DIV clks with `mdc`=0, then MDC_DIV clks with `mdc`=1.
- Output bits change at the start of the low phase, i.e. at the MDC falling edge.
- Input bits are sampled on the clk at which `mdc` rises.
- With the accept at cycle t:
  - Bit k (0..63) starts at t+1+2k*MDC_DIV.
  - `rsp_valid`=1 at t+1+128*MDC_DIV.
  - The earliest next accept is t+2+128*MDC_DIV.
- `mdc` is 0 in IDLE and DONE. There is no idle bit between back-to-back frames beyond the DONE/IDLE cycles.
- If `cmd_valid` drops before ready, there is no accept and no state change.
- Asserting `rst` mid-frame aborts the frame immediately:
  - No `rsp_valid`.
  - `mdio` released and `mdc`=0 at once.
  - The latched command is discarded; the requester must reissue it.
- A bit counter sized for 0..31 (PRE) and 0..15 (DATA) must not wrap into a spurious extra bit. Each state exits exactly at its last bit boundary.

## Test plan
- Write, port 2, phy 5, reg 0, wdata 0x1140, MDC_DIV=10 → frame on `mdio[2]` is 32×1, 0101, 00101, 00000, 10, 0001000101000000. `rsp_valid` at t+1281 with `rsp_port`=2, `rsp_err`=0, `rsp_rdata`=0. `mdio[0,1,3]` are z throughout.
- Read, port 1, phy 1, reg 2; PHY model drives TA bit 2 = 0 and data 0xABCD → `rsp_rdata`=0xABCD, `rsp_err`=0. The controller never drives `mdio[1]` after the REGAD LSB.
- Read, port 3, no PHY attached (line floats/pulled high) → `rsp_err`=1, `rsp_rdata`=0xFFFF, full-length frame.
- All four `cmd_valid` held high from reset → accept order 0,1,2,3,0. Dropping port 1 after its first grant → order 0,1,2,3,0,2,3.
- Assert `rst` at bit 40 of a write → `mdc`=0 and all `mdio` z within the same cycle, no `rsp_valid`, `busy`=0. A new command afterwards is granted from port 0.
- MDC_DIV=2, back-to-back reads on port 0 → `mdc` period 4 clks, `rsp_valid` spacing 258 clks, `cmd_ready` high only in IDLE.

Source files
------------

// File: rtl/mdio_ctrl_if.sv
// mdio_ctrl_if: per-port command channels and shared response channel
// for the multi-port MDIO management controller.
interface mdio_ctrl_if #(
  parameter int NUM_PORTS = 4
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]    cmd_valid;
  logic [NUM_PORTS-1:0]    cmd_ready;
  logic [NUM_PORTS-1:0]    cmd_wr;
  logic [5*NUM_PORTS-1:0]  cmd_phy;
  logic [5*NUM_PORTS-1:0]  cmd_reg;
  logic [16*NUM_PORTS-1:0] cmd_wdata;
  logic                    rsp_valid;
  logic [PW-1:0]           rsp_port;
  logic [15:0]             rsp_rdata;
  logic                    rsp_err;
  logic                    busy;

  modport master (
    output cmd_valid, cmd_wr, cmd_phy, cmd_reg, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_port, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_phy, cmd_reg, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_port, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/mdio_ctrl.sv
// mdio_ctrl: multi-port Clause 22 MDIO master, round-robin over
// per-port command channels, one 64-bit frame at a time on shared MDC.
module mdio_ctrl #(
  parameter int NUM_PORTS = 4,
  parameter int MDC_DIV   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  mdio_ctrl_if.slave           bus,
  output logic                 mdc,
  inout  wire  [NUM_PORTS-1:0] mdio
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DW = $clog2(2 * MDC_DIV);
  localparam logic [DW-1:0] DIV_LO  = DW'(MDC_DIV - 1);
  localparam logic [DW-1:0] DIV_HI  = DW'(MDC_DIV);
  localparam logic [DW-1:0] DIV_END = DW'(2 * MDC_DIV - 1);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [PW-1:0]   port_q, port_d;
  logic            wr_q, wr_d;
  logic [4:0]      phy_q, phy_d;
  logic [4:0]      reg_q, reg_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [PW-1:0]   rsp_port_q, rsp_port_d;
  logic [15:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [PW-1:0]        grant;
  logic [PW:0]          idx;
  logic                 found;
  logic [NUM_PORTS-1:0] mdio_in;
  logic                 rx_bit;
  logic                 bit_end;
  logic                 sample;
  logic                 frame;
  logic                 oe;
  logic                 dout;
  logic [4:0]           last;
  logic [13:0]          hdr;

  // first requester at or above rr, wrapping
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = {1'b0, rr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
      if (!found && bus.cmd_valid[idx[PW-1:0]]) begin
        found = 1'b1;
        grant = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    bus.cmd_ready = '0;
    if (state_q == IDLE && found) bus.cmd_ready[grant] = 1'b1;
  end

  assign mdio_in = mdio;
  assign bit_end = (div_q == DIV_END);
  assign sample  = (div_q == DIV_LO);
  assign frame   = state_q inside {PRE, HDR, TA, DATA};
  assign mdc     = frame && (div_q >= DIV_HI);
  assign hdr     = {2'b01, wr_q ? 2'b01 : 2'b10, phy_q, reg_q};

  // anything other than a clean 0 (z, x, 1) reads as 1
  always_comb begin
    rx_bit = 1'b1;
    if (mdio_in[port_q] == 1'b0) rx_bit = 1'b0;
  end

  always_comb begin
    last = 5'd15;
    unique case (state_q)
      PRE:     last = 5'd31;
      HDR:     last = 5'd13;
      TA:      last = 5'd1;
      default: last = 5'd15;
    endcase
  end

  always_comb begin
    oe   = 1'b0;
    dout = 1'b1;
    unique case (state_q)
      PRE: oe = 1'b1;
      HDR: begin
        oe   = 1'b1;
        dout = hdr[4'd13 - cnt_q[3:0]];
      end
      TA: begin
        oe   = wr_q;
        dout = (cnt_q == 5'd0);
      end
      DATA: begin
        oe   = wr_q;
        dout = wdata_q[4'd15 - cnt_q[3:0]];
      end
      default: ;
    endcase
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pin
    assign mdio[p] = (oe && port_q == PW'(p)) ? dout : 1'bz;
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    port_d      = port_q;
    wr_d        = wr_q;
    phy_d       = phy_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_port_d  = rsp_port_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          port_d  = grant;
          wr_d    = bus.cmd_wr[grant];
          phy_d   = bus.cmd_phy[5*grant +: 5];
          reg_d   = bus.cmd_reg[5*grant +: 5];
          wdata_d = bus.cmd_wdata[16*grant +: 16];
          rr_d    = (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
          div_d   = '0;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = PRE;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        div_d = bit_end ? '0 : div_q + 1'b1;
        if (sample && !wr_q) begin
          if (state_q == TA && cnt_q == 5'd1) err_d = rx_bit;
          if (state_q == DATA) rdata_d = {rdata_q[14:0], rx_bit};
        end
        if (bit_end) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last) begin
            cnt_d = '0;
            unique case (state_q)
              PRE: state_d = HDR;
              HDR: state_d = TA;
              TA:  state_d = DATA;
              default: begin
                state_d     = DONE;
                rsp_port_d  = port_q;
                rsp_rdata_d = wr_q ? 16'h0 : rdata_q;
                rsp_err_d   = wr_q ? 1'b0 : err_q;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      rr_q        <= '0;
      port_q      <= '0;
      wr_q        <= 1'b0;
      phy_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_port_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      port_q      <= port_d;
      wr_q        <= wr_d;
      phy_q       <= phy_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_port_q  <= rsp_port_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_port  = rsp_port_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mdio_ctrl.sv
// tb_mdio_ctrl: directed vectors for mdio_ctrl, one instance at
// MDC_DIV=10 and one at MDC_DIV=2, with simple timed PHY models.
`timescale 1ns/1ps
module tb_mdio_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mdio_ctrl_if #(.NUM_PORTS(4)) ba();
  mdio_ctrl_if #(.NUM_PORTS(4)) bb();
  wire  [3:0] mda;
  wire  [3:0] mdb;
  logic       mdc_a;
  logic       mdc_b;

  mdio_ctrl #(.NUM_PORTS(4), .MDC_DIV(10)) u_a (
    .clk(clk), .rst(rst), .bus(ba), .mdc(mdc_a), .mdio(mda)
  );
  mdio_ctrl #(.NUM_PORTS(4), .MDC_DIV(2)) u_b (
    .clk(clk), .rst(rst), .bus(bb), .mdc(mdc_b), .mdio(mdb)
  );

  logic [3:0]  pa_en = '0;
  logic [3:0]  pb_en = '0;
  logic [15:0] pa_dat [4];
  logic [15:0] pb_dat [4];
  int          ta0 [4] = '{default: -100000};
  int          tb0 [4] = '{default: -100000};
  logic [3:0]  pa_oe, pa_v, pb_oe, pb_v;

  // PHY drives TA bit 2 low, then 16 data bits, from the accept time
  function automatic logic [1:0] phy(int c, int t0, int d, logic [15:0] dat);
    int k;
    if (c <= t0) return 2'b00;
    k = (c - t0 - 1) / (2 * d);
    if (k == 47) return 2'b10;
    if (k >= 48 && k <= 63) return {1'b1, dat[63-k]};
    return 2'b00;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      {pa_oe[i], pa_v[i]} = pa_en[i] ? phy(cyc, ta0[i], 10, pa_dat[i]) : 2'b00;
      {pb_oe[i], pb_v[i]} = pb_en[i] ? phy(cyc, tb0[i], 2, pb_dat[i]) : 2'b00;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_pin
    pullup (mda[i]);
    pullup (mdb[i]);
    assign mda[i] = pa_oe[i] ? pa_v[i] : 1'bz;
    assign mdb[i] = pb_oe[i] ? pb_v[i] : 1'bz;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  int         acc_port [$];
  int         acc_t [$];
  int         rsp_tb [$];
  int         rsp_na = 0;
  int         rsp_ta = 0;
  int         bad_ready = 0;
  int         bad_other = 0;
  logic [3:0] watch = '0;

  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (ba.cmd_valid[p] && ba.cmd_ready[p]) begin
        acc_port.push_back(p);
        acc_t.push_back(cyc);
        ta0[p] = cyc;
      end
      if (bb.cmd_valid[p] && bb.cmd_ready[p]) tb0[p] = cyc;
    end
    if ($countones(ba.cmd_ready) > 1 || (ba.busy && ba.cmd_ready != 0))
      bad_ready++;
    if ($countones(bb.cmd_ready) > 1 || (bb.busy && bb.cmd_ready != 0))
      bad_ready++;
    if (ba.rsp_valid) begin
      rsp_na++;
      rsp_ta = cyc;
    end
    if (bb.rsp_valid) rsp_tb.push_back(cyc);
    if ((mda & watch) != watch) bad_other++;
  end

  logic [63:0] cap_a = '0;
  int          ncap_a = 0;
  int          cap_port = 0;
  always @(posedge mdc_a) begin
    cap_a = {cap_a[62:0], mda[cap_port]};
    ncap_a++;
  end

  int mb_last = -1;
  int mb_per = -1;
  always @(posedge mdc_b) begin
    if (mb_last >= 0 && mb_per < 0) mb_per = cyc - mb_last;
    mb_last = cyc;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int p, input logic wr, input logic [4:0] ph,
                        input logic [4:0] rg, input logic [15:0] wd);
    ba.cmd_wr[p]            = wr;
    ba.cmd_phy[5*p +: 5]    = ph;
    ba.cmd_reg[5*p +: 5]    = rg;
    ba.cmd_wdata[16*p +: 16] = wd;
    ba.cmd_valid[p]         = 1'b1;
  endtask

  task automatic wait_acc(input int n, input int lim, input string tag);
    int c = 0;
    while (acc_port.size() < n && c < lim) begin
      tick(1);
      c++;
    end
    check(tag, 64'(acc_port.size() >= n), 64'd1);
  endtask

  task automatic wait_rsp(input int n, input int lim, input string tag);
    int c = 0;
    while (rsp_na < n && c < lim) begin
      tick(1);
      c++;
    end
    check(tag, 64'(rsp_na), 64'(n));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  localparam logic [63:0] FR_W =
    {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd5, 5'd0, 2'b10, 16'h1140};
  localparam logic [63:0] FR_R =
    {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd2, 2'b10, 16'hABCD};

  initial begin
    int base;
    int nb;
    int tgt;
    int exp_rr [7] = '{0, 1, 2, 3, 0, 2, 3};
    ba.cmd_valid = '0; ba.cmd_wr = '0; ba.cmd_phy = '0;
    ba.cmd_reg = '0; ba.cmd_wdata = '0;
    bb.cmd_valid = '0; bb.cmd_wr = '0; bb.cmd_phy = '0;
    bb.cmd_reg = '0; bb.cmd_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      pa_dat[i] = '0;
      pb_dat[i] = '0;
    end
    rst = 1'b1;
    tick(3);
    check("rst_busy", 64'(ba.busy), 64'd0);
    check("rst_ready", 64'(ba.cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(ba.rsp_valid), 64'd0);
    check("rst_rsp_port", 64'(ba.rsp_port), 64'd0);
    check("rst_rdata", 64'(ba.rsp_rdata), 64'd0);
    check("rst_err", 64'(ba.rsp_err), 64'd0);
    check("rst_mdc", 64'(mdc_a), 64'd0);
    check("rst_mdio", 64'(mda), 64'hF);
    rst = 1'b0;
    tick(2);

    // write port 2, phy 5, reg 0, 0x1140
    cap_port = 2;
    ncap_a   = 0;
    watch    = 4'b1011;
    send_a(2, 1'b1, 5'd5, 5'd0, 16'h1140);
    wait_acc(1, 10, "w_acc");
    ba.cmd_valid[2] = 1'b0;
    tick(100);
    check("w_busy", 64'(ba.busy), 64'd1);
    wait_rsp(1, 1400, "w_rsp");
    watch = '0;
    check("w_frame", cap_a, FR_W);
    check("w_nbits", 64'(ncap_a), 64'd64);
    check("w_lat", 64'(rsp_ta - acc_t[0]), 64'd1281);
    check("w_port", 64'(ba.rsp_port), 64'd2);
    check("w_err", 64'(ba.rsp_err), 64'd0);
    check("w_rdata", 64'(ba.rsp_rdata), 64'd0);
    check("w_other_z", 64'(bad_other), 64'd0);

    // read port 1 with PHY answering 0xABCD
    cap_port  = 1;
    ncap_a    = 0;
    pa_dat[1] = 16'hABCD;
    pa_en[1]  = 1'b1;
    send_a(1, 1'b0, 5'd1, 5'd2, 16'h0);
    wait_acc(2, 10, "r_acc");
    ba.cmd_valid[1] = 1'b0;
    wait_rsp(2, 1400, "r_rsp");
    pa_en[1] = 1'b0;
    check("r_frame", cap_a, FR_R);
    check("r_rdata", 64'(ba.rsp_rdata), 64'hABCD);
    check("r_err", 64'(ba.rsp_err), 64'd0);
    check("r_port", 64'(ba.rsp_port), 64'd1);

    // read port 3, nothing attached
    send_a(3, 1'b0, 5'd7, 5'd1, 16'h0);
    wait_acc(3, 10, "n_acc");
    ba.cmd_valid[3] = 1'b0;
    wait_rsp(3, 1400, "n_rsp");
    check("n_err", 64'(ba.rsp_err), 64'd1);
    check("n_rdata", 64'(ba.rsp_rdata), 64'hFFFF);
    check("n_port", 64'(ba.rsp_port), 64'd3);
    check("n_lat", 64'(rsp_ta - acc_t[2]), 64'd1281);

    // reset in the middle of bit 40 of a write
    send_a(1, 1'b1, 5'd0, 5'd4, 16'h5555);
    wait_acc(4, 10, "x_acc");
    ba.cmd_valid[1] = 1'b0;
    tgt = acc_t[3] + 1 + 40 * 20 + 13;
    while (cyc < tgt) tick(1);
    check("x_mdc_pre", 64'(mdc_a), 64'd1);
    check("x_mdio_pre", 64'(mda[1]), 64'd0);
    rst = 1'b1;
    #1;
    check("x_mdc", 64'(mdc_a), 64'd0);
    check("x_mdio", 64'(mda), 64'hF);
    check("x_busy", 64'(ba.busy), 64'd0);
    tick(2);
    rst = 1'b0;
    tick(3);
    check("x_norsp", 64'(rsp_na), 64'd3);
    send_a(1, 1'b1, 5'd0, 5'd0, 16'h0);
    send_a(3, 1'b1, 5'd0, 5'd0, 16'h0);
    wait_acc(5, 10, "x_acc2");
    ba.cmd_valid = '0;
    check("x_grant", 64'(acc_port[4]), 64'd1);
    wait_rsp(4, 1400, "x_rsp");

    // round robin, all requesting, port 1 drops after its grant
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    base = acc_port.size();
    for (int p = 0; p < 4; p++) send_a(p, 1'b1, 5'(p), 5'd3, 16'(p));
    wait_acc(base + 2, 3000, "rr_acc2");
    ba.cmd_valid[1] = 1'b0;
    wait_acc(base + 7, 7000, "rr_acc7");
    ba.cmd_valid = '0;
    for (int i = 0; i < 7; i++)
      check($sformatf("rr_order%0d", i), 64'(acc_port[base+i]), 64'(exp_rr[i]));
    wait_rsp(rsp_na + 1, 1400, "rr_rsp");

    // MDC_DIV=2 back-to-back reads on port 0
    nb        = rsp_tb.size();
    pb_dat[0] = 16'h5A3C;
    pb_en[0]  = 1'b1;
    bb.cmd_wr[0]    = 1'b0;
    bb.cmd_phy[4:0] = 5'd7;
    bb.cmd_reg[4:0] = 5'd9;
    bb.cmd_valid[0] = 1'b1;
    for (int c = 0; c < 1000 && rsp_tb.size() < nb + 3; c++) tick(1);
    bb.cmd_valid[0] = 1'b0;
    check("b_nrsp", 64'(rsp_tb.size() >= nb + 3), 64'd1);
    check("b_gap1", 64'(rsp_tb[nb+1] - rsp_tb[nb]), 64'd258);
    check("b_gap2", 64'(rsp_tb[nb+2] - rsp_tb[nb+1]), 64'd258);
    check("b_rdata", 64'(bb.rsp_rdata), 64'h5A3C);
    check("b_err", 64'(bb.rsp_err), 64'd0);
    check("b_mdc_per", 64'(mb_per), 64'd4);
    check("ready_idle_onehot", 64'(bad_ready), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
